// File: rtl/lsu_ram_resp.sv
// Word-addressed data RAM behind the LSU request/response handshake.
// Each request takes WAIT_CYC wait states, then gives a one-cycle ready pulse.
module lsu_ram_resp #(
  parameter int XLEN     = 32,
  parameter int DEPTH    = 1024,
  parameter int WAIT_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lsu_ram_valid,
  input  logic            lsu_ram_rd,
  input  logic            lsu_ram_wr,
  input  logic [XLEN-1:0] lsu_ram_addr,
  input  logic [XLEN-1:0] lsu_ram_wdata,
  output logic [XLEN-1:0] ram_lsu_rdata,
  output logic            ram_lsu_ready,
  output logic            ram_lsu_err,
  output logic [1:0]      fsm_state
);

  // Handshake: the requester holds valid (and its payload) until ready. A request
  // is taken on the first edge where the FSM is IDLE and valid=1. After that,
  // every input is ignored until ready has pulsed for exactly one cycle.

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [3:0]      cnt;
  logic            rd_q;
  logic            wr_q;
  logic            oor_q;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] wdata_q;

  logic [XLEN-1:0] mem [DEPTH];

  logic            enter_resp;
  logic            cur_rd;
  logic            cur_wr;
  logic            cur_oor;
  logic [AW-1:0]   cur_idx;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (lsu_ram_valid) state_nxt = (WAIT_CYC == 0) ? S_RESP : S_BUSY;
      S_BUSY:  if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign enter_resp = (state_nxt == S_RESP) && (state != S_RESP);

  // With zero wait states the read happens on the accept edge itself, so it
  // must see the live request instead of the latched copy.
  always_comb begin
    cur_rd  = rd_q;
    cur_wr  = wr_q;
    cur_oor = oor_q;
    cur_idx = idx_q;
    if (state == S_IDLE) begin
      cur_rd  = lsu_ram_rd;
      cur_wr  = lsu_ram_wr;
      cur_oor = (lsu_ram_addr >= XLEN'(DEPTH));
      cur_idx = lsu_ram_addr[AW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (lsu_ram_valid) begin
            cnt     <= CNT_INIT;
            rd_q    <= lsu_ram_rd;
            wr_q    <= lsu_ram_wr;
            oor_q   <= (lsu_ram_addr >= XLEN'(DEPTH));
            idx_q   <= lsu_ram_addr[AW-1:0];
            wdata_q <= lsu_ram_wdata;
          end
        end
        S_BUSY: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        default: cnt <= 4'd0;
      endcase
    end
  end

  // Read data is captured as the FSM enters RESP, so it is valid during ready.
  // An out-of-range read returns zero. A write (even with rd set) leaves it untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_lsu_rdata <= '0;
    end else if (enter_resp && cur_rd && !cur_wr) begin
      ram_lsu_rdata <= cur_oor ? '0 : mem[cur_idx];
    end
  end

  // Writes commit on the edge that leaves RESP. A reset before that drops them.
  always_ff @(posedge clk) begin
    if (state == S_RESP && wr_q && !oor_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign ram_lsu_ready = (state == S_RESP);
  assign ram_lsu_err   = ram_lsu_ready && oor_q && (rd_q || wr_q);
  assign fsm_state     = state;

endmodule

// File: tb/tb_lsu_ram_resp.sv
// Self-checking bench for lsu_ram_resp: table-driven requests plus a response scoreboard,
// with hand-written sequences for valid drop, mid-transaction reset, and zero wait states.
module tb_lsu_ram_resp;

  localparam int XLEN = 32;
  localparam int WAIT_CYC = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT (WAIT_CYC=2)
  logic            valid, rd, wr;
  logic [XLEN-1:0] addr, wdata;
  logic [XLEN-1:0] rdata;
  logic            ready, err;
  logic [1:0]      fsm_state;

  // zero-wait DUT
  logic            v0, rd0, wr0;
  logic [XLEN-1:0] a0, wd0;
  logic [XLEN-1:0] rdata0;
  logic            ready0, err0;
  logic [1:0]      fsm_state0;

  lsu_ram_resp #(.XLEN(XLEN), .DEPTH(1024), .WAIT_CYC(WAIT_CYC)) dut (
    .clk(clk), .rst(rst),
    .lsu_ram_valid(valid), .lsu_ram_rd(rd), .lsu_ram_wr(wr),
    .lsu_ram_addr(addr), .lsu_ram_wdata(wdata),
    .ram_lsu_rdata(rdata), .ram_lsu_ready(ready), .ram_lsu_err(err),
    .fsm_state(fsm_state)
  );

  lsu_ram_resp #(.XLEN(XLEN), .DEPTH(1024), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst),
    .lsu_ram_valid(v0), .lsu_ram_rd(rd0), .lsu_ram_wr(wr0),
    .lsu_ram_addr(a0), .lsu_ram_wdata(wd0),
    .ram_lsu_rdata(rdata0), .ram_lsu_ready(ready0), .ram_lsu_err(err0),
    .fsm_state(fsm_state0)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard: {err, rdata} expected per response, in order
  logic [XLEN:0] exp_q[$];
  logic          prev_ready = 1'b0;

  always @(negedge clk) begin
    logic [XLEN:0] e;
    if (ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL spurious_ready: got ready=1 expected no response (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", rdata, e[XLEN-1:0]);
        check("resp_err", {31'b0, err}, {31'b0, e[XLEN]});
      end
      if (prev_ready) check("ready_width", {31'b0, prev_ready}, 32'd0);
    end else if (err) begin
      check("err_without_ready", {31'b0, err}, 32'd0);
    end
    prev_ready = ready;
  end

  // driver tasks
  task automatic wait_ready(output int lat);
    bit got;
    got = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (ready) begin
        got = 1'b1;
        lat = i;
      end
    end
  endtask

  task automatic finish_req();
    int lat;
    @(posedge clk);
    wait_ready(lat);
    valid = 1'b0;
    rd    = 1'b0;
    wr    = 1'b0;
    check("latency", 32'(lat), 32'(WAIT_CYC + 1));
  endtask

  task automatic issue(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rdata, input logic exp_err);
    valid = 1'b1;
    rd    = r;
    wr    = w;
    addr  = a;
    wdata = d;
    exp_q.push_back({exp_err, exp_rdata});
    finish_req();
  endtask

  task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rdata, input logic exp_err);
    @(negedge clk);
    issue(r, w, a, d, exp_rdata, exp_err);
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];
  logic [31:0] cur_rdata;

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish (t=%0t)", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ra, rdv;
    int lat, pulses;
    logic exp_rdy;

    vecs[0]  = '{1'b0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0005, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0000, 32'h1111_1111, 32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0000_0400, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 32'h0000_0400, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[5]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h1111_1111, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'h0000_0009, 32'hA5A5_A5A5, 32'h1111_1111, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 32'h0000_0009, 32'h0000_0000, 32'hA5A5_A5A5, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 32'h0000_0009, 32'h5555_5555, 32'hA5A5_A5A5, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_03FF, 32'hCAFE_F00D, 32'hA5A5_A5A5, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_03FF, 32'h0000_0000, 32'hCAFE_F00D, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_0003, 32'h0BAD_C0DE, 32'h0000_0000, 1'b0};

    valid = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
    v0 = 1'b0; rd0 = 1'b0; wr0 = 1'b0; a0 = '0; wd0 = '0;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_state_idle", {30'b0, fsm_state}, 32'd0);
    check("rst_ready0", {31'b0, ready0}, 32'd0);
    rst = 1'b0;

    // table-driven vectors
    foreach (vecs[i]) begin
      do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
    end
    cur_rdata = vecs[12].exp_rdata;

    // valid dropped (and payload scrambled) right after accept: write must still land
    @(negedge clk);
    valid = 1'b1; rd = 1'b0; wr = 1'b1; addr = 32'h7; wdata = 32'h7777_7777;
    exp_q.push_back({1'b0, cur_rdata});
    @(posedge clk);
    #1;
    valid = 1'b0; rd = 1'b1; wr = 1'b0; addr = 32'h55; wdata = 32'h0;
    wait_ready(lat);
    rd = 1'b0;
    check("drop_latency", 32'(lat), 32'(WAIT_CYC + 1));
    do_req(1'b1, 1'b0, 32'h7, 32'h0, 32'h7777_7777, 1'b0);
    cur_rdata = 32'h7777_7777;

    // reset during BUSY of a write: discarded, no ready, memory retained
    @(negedge clk);
    valid = 1'b1; rd = 1'b0; wr = 1'b1; addr = 32'h3; wdata = 32'h1234_5678;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1; valid = 1'b0; wr = 1'b0;
    #1;
    check("midrst_rdata", rdata, 32'd0);
    check("midrst_ready", {31'b0, ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // first request accepted on the first edge after reset release
    issue(1'b1, 1'b0, 32'h3, 32'h0, 32'h0BAD_C0DE, 1'b0);
    cur_rdata = 32'h0BAD_C0DE;

    // random write-then-read pairs
    for (int k = 0; k < 8; k++) begin
      ra  = 32'($urandom_range(16, 1000));
      rdv = $urandom;
      do_req(1'b0, 1'b1, ra, rdv, cur_rdata, 1'b0);
      do_req(1'b1, 1'b0, ra, 32'h0, rdv, 1'b0);
      cur_rdata = rdv;
    end

    // zero wait states: one write, then valid held high across three reads
    @(negedge clk);
    v0 = 1'b1; wr0 = 1'b1; a0 = 32'h2; wd0 = 32'h1357_9BDF;
    @(posedge clk);
    @(negedge clk);
    check("w0_ready", {31'b0, ready0}, 32'd1);
    check("w0_err", {31'b0, err0}, 32'd0);
    v0 = 1'b0; wr0 = 1'b0;
    @(negedge clk);
    v0 = 1'b1; rd0 = 1'b1;
    pulses = 0;
    @(posedge clk);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_rdy = (k == 1 || k == 3 || k == 5);
      check($sformatf("w0_ready_c%0d", k), {31'b0, ready0}, {31'b0, exp_rdy});
      if (ready0) begin
        pulses++;
        check("w0_rdata", rdata0, 32'h1357_9BDF);
        check("w0_rerr", {31'b0, err0}, 32'd0);
      end
      if (k == 5) begin
        v0 = 1'b0; rd0 = 1'b0;
      end
    end
    check("w0_pulses", 32'(pulses), 32'd3);

    repeat (4) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lsu_ram_resp.md
LSU_RAM_RESP -- requirements
Module: lsu_ram_resp

Interface
REQ-001 Parameter XLEN, default 32, data and address width.
REQ-002 Parameter DEPTH, default 1024, number of XLEN-bit words in the array.
REQ-003 Parameter WAIT_CYC, default 2, wait states inserted before each response; legal range 0-15.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1, asynchronous active-high reset.
REQ-006 Port lsu_ram_valid, input, 1, request valid; held by the requester until ram_lsu_ready.
REQ-007 Port lsu_ram_rd, input, 1, read request.
REQ-008 Port lsu_ram_wr, input, 1, write request.
REQ-009 Port lsu_ram_addr, input, XLEN, word address, already shifted right by 2.
REQ-010 Port lsu_ram_wdata, input, XLEN, full-word write data; the requester performs sub-word merging.
REQ-011 Port ram_lsu_rdata, output, XLEN, registered read data.
REQ-012 Port ram_lsu_ready, output, 1, single-cycle completion pulse for reads and writes.
REQ-013 Port ram_lsu_err, output, 1, address-out-of-range flag, valid only while ram_lsu_ready is high.

Function
REQ-014 FSM states: IDLE, BUSY, RESP; encoding is implementation choice.
REQ-015 IDLE with lsu_ram_valid=1: accept the request and latch addr, rd, wr and wdata. Next state is BUSY with wait counter=WAIT_CYC-1, or RESP directly when WAIT_CYC=0.
REQ-016 BUSY: decrement the counter each cycle; at count 0 the next state is RESP.
REQ-017 Requests are non-aborting: input changes, including valid deasserting, during BUSY/RESP are ignored.
REQ-018 RESP: assert ram_lsu_ready for exactly one cycle; next state is IDLE unconditionally.
REQ-019 Latency: ready is asserted WAIT_CYC+1 cycles after the accepting edge.
REQ-020 After RESP there is a minimum of one IDLE cycle, so back-to-back requests are spaced WAIT_CYC+2 cycles.
REQ-021 Write, in range: mem[addr] <= wdata on the RESP edge; ram_lsu_rdata is unchanged.
REQ-022 Read, in range: ram_lsu_rdata <= mem[addr] on the BUSY-to-RESP edge (IDLE-to-RESP when WAIT_CYC=0), so data is valid while ready=1.
REQ-023 ram_lsu_rdata holds its value until the next completed read.
REQ-024 rd=1 and wr=1 together: write takes priority and no read is performed.
REQ-025 rd=0 and wr=0 with valid=1: ready pulses with no memory or rdata change and err=0.
REQ-026 addr >= DEPTH: the write is suppressed; a read returns rdata=0; ram_lsu_err=1 during the ready cycle.
REQ-027 ram_lsu_err is 0 whenever ram_lsu_ready is 0.
REQ-028 A read of a word written by the immediately preceding request returns the new data.

Reset
REQ-029 rst=1 asynchronously forces state=IDLE, counter=0, ram_lsu_ready=0, ram_lsu_err=0 and ram_lsu_rdata=0.
REQ-030 Reset mid-transaction discards the pending request; a pending write is not committed and no ready is produced.
REQ-031 Memory contents are not cleared by reset and are retained across it.
REQ-032 The first request is accepted on the first rising edge after rst deasserts.

Verification
REQ-033 WAIT_CYC=2: write addr=0x5 wdata=0xDEADBEEF, then read addr=0x5 -> each ready arrives 3 cycles after accept; read returns rdata=0xDEADBEEF with err=0.
REQ-034 Read addr=0x400 (DEPTH=1024) -> ready with err=1 and rdata=0x00000000; a write to 0x400 leaves mem[0x000] unchanged.
REQ-035 Valid dropped one cycle after accept -> ready still pulses once on schedule and the write to addr 0x7 is committed.
REQ-036 rst pulsed during BUSY of a write 0x12345678 to addr 0x3 -> no ready; a later read of 0x3 returns the pre-reset value.
REQ-037 WAIT_CYC=0 with valid held high continuously for 3 reads -> ready on cycles 1, 3, 5 after the first accept; exactly one pulse per request.
REQ-038 rd=1 and wr=1 with addr=0x9 wdata=0xA5A5A5A5 -> mem[0x9]=0xA5A5A5A5 and rdata unchanged.
